// File: rtl/shim_split_pkg.sv
// Shared shim definitions: the two-state handshake encoding used by every shim
// block, plus a constant-evaluable ceil(log2) helper for sizing counters/indices.
package shim_split_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } shim_state_e;

  // ceil(log2(n)), minimum 1 so a single-entry index still has a bit.
  function automatic int shim_clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/shim_split_lane.sv
// One consumer lane of the scatter shim.
// Holds a pending flag that is set when the top captures a vector and cleared
// once the downstream consumer accepts (VALID && READY).
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   LOAD      set pending (top only asserts this while every lane is idle)
//   READY     downstream accept for this lane
//   VALID     registered pending flag, drives the lane's valid
//   ACCEPT    this lane is being accepted in the current cycle
module shim_split_lane (
  input  logic CLK,
  input  logic RST,
  input  logic LOAD,
  input  logic READY,
  output logic VALID,
  output logic ACCEPT
);

  logic pending;

  // READY on a lane that is not pending has no effect.
  assign ACCEPT = pending && READY;
  assign VALID  = pending;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= 1'b0;
    end else if (LOAD) begin
      pending <= 1'b1;
    end else if (ACCEPT) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/shim_split.sv
// Scatter shim: captures one wide signed vector on VALID_IN/READY_OUT and
// offers each WIDTH slice to its own consumer on an independent valid/ready
// handshake. The vector is held until every lane has accepted, then DONE_OUT
// pulses for one cycle and the block re-opens for the next vector.
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   VALUES_IN    source vector, lane d = [d*WIDTH +: WIDTH]
//   VALID_IN     source strobe
//   READY_OUT    high in IDLE only
//   VALUES_OUT   captured vector, stable while any lane is pending
//   VALIDS_OUT   per-lane valid (lane pending)
//   READYS_IN    per-lane accept
//   DONE_OUT     one-cycle pulse after the last pending lane is accepted
//   OVERRUN_OUT  sticky flag: VALID_IN arrived while READY_OUT was low
module shim_split
  import shim_split_pkg::*;
#(
  parameter int NUM_OUTPUTS = 1,
  parameter int WIDTH       = 8
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic signed [NUM_OUTPUTS*WIDTH-1:0] VALUES_IN,
  input  logic                                VALID_IN,
  output logic                                READY_OUT,
  output logic signed [NUM_OUTPUTS*WIDTH-1:0] VALUES_OUT,
  output logic        [NUM_OUTPUTS-1:0]       VALIDS_OUT,
  input  logic        [NUM_OUTPUTS-1:0]       READYS_IN,
  output logic                                DONE_OUT,
  output logic                                OVERRUN_OUT
);

  shim_state_e                         state_q;
  logic signed [NUM_OUTPUTS*WIDTH-1:0] values_p1;
  logic        [NUM_OUTPUTS-1:0]       pending;
  logic        [NUM_OUTPUTS-1:0]       accept;
  logic                                load;
  logic                                last_accept;
  logic                                done_q;
  logic                                overrun_q;

  assign READY_OUT = (state_q == ST_IDLE);
  assign load      = VALID_IN && READY_OUT;

  // Every lane still pending is accepted this cycle (several may finish together).
  assign last_accept = (state_q == ST_BUSY) && ((pending & ~accept) == '0);

  genvar d;
  generate
    for (d = 0; d < NUM_OUTPUTS; d++) begin : g_lane
      shim_split_lane u_lane (
        .CLK   (CLK),
        .RST   (RST),
        .LOAD  (load),
        .READY (READYS_IN[d]),
        .VALID (pending[d]),
        .ACCEPT(accept[d])
      );
    end
  endgenerate

  // Capture stage: vector register, written only on an accepted VALID_IN,
  // so it cannot change while any lane is pending.
  always_ff @(posedge CLK) begin
    if (RST) begin
      values_p1 <= '0;
    end else if (load) begin
      values_p1 <= VALUES_IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= last_accept;
      if (VALID_IN && !READY_OUT) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: if (load)        state_q <= ST_BUSY;
        ST_BUSY: if (last_accept) state_q <= ST_IDLE;
        default:                  state_q <= ST_IDLE;
      endcase
    end
  end

  assign VALUES_OUT  = values_p1;
  assign VALIDS_OUT  = pending;
  assign DONE_OUT    = done_q;
  assign OVERRUN_OUT = overrun_q;

endmodule
